// File: rtl/riscv_pkg.sv
// Shared pipeline types: memory operation codes, trap codes and
// the per-request metadata tracked between MEM2 issue and LSU response.
package riscv_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_LWU = 4'd6,
        MEM_LD  = 4'd7,
        MEM_SB  = 4'd8,
        MEM_SH  = 4'd9,
        MEM_SW  = 4'd10,
        MEM_SD  = 4'd11
    } mem_oper_t;

    typedef enum logic [3:0] {
        NO_TRAP            = 4'd0,
        EXC_ILLEGAL        = 4'd1,
        EXC_ECALL          = 4'd2,
        EXC_EBREAK         = 4'd3,
        EXC_LOAD_MISALIGN  = 4'd4,
        EXC_STORE_MISALIGN = 4'd5
    } exc_t;

    typedef struct packed {
        mem_oper_t  oper;
        logic [2:0] offset;
        logic       write_rd;
        logic [4:0] rd;
        logic       kill;
    } mem_meta_t;

endpackage

// File: rtl/lsu_resp_queue.sv
// In-order circular buffer of outstanding LSU request metadata,
// with a per-slot kill flag that a pipeline flush sets on every entry.
module lsu_resp_queue #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output T              head_o,
    output logic          head_kill_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    T               mem_q [DEPTH];
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           do_push, do_pop;

    // Pointers wrap at DEPTH, so non-power-of-two depths work.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign head_kill_o = kill_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = do_pop  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        kill_d   = flush_i ? '1 : kill_q;
        if (do_push) begin
            kill_d[wr_ptr_q] = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            kill_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            kill_q   <= kill_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/stage_mem2_mo.sv
// MEM2 stage with multiple outstanding LSU requests: in-order tracking,
// load data formatting, in-order retirement to WB and CSR commit gating.
module stage_mem2_mo
    import riscv_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  mem_oper_t       mem_oper_i,
    input  logic            write_rd_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic [11:0]     csr_waddr_i,
    input  logic            csr_we_i,
    input  exc_t            trap_i,
    input  logic            flush_i,
    input  logic            lsu_rvalid_i,
    input  logic [XLEN-1:0] lsu_rdata_i,
    input  logic            lsu_err_i,
    output logic            csr_we_o,
    output logic [11:0]     csr_waddr_o,
    output logic [XLEN-1:0] csr_wdata_o,
    output logic            wb_valid_o,
    output logic            write_rd_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] wb_data_o,
    output mem_oper_t       mem_oper_o,
    output logic            load_fault_o,
    output logic            stall_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int OW = $clog2(XLEN / 8);

    logic            is_mem, accept, push;
    logic            q_full, q_empty, head_kill, head_dead;
    logic [CW-1:0]   q_count;
    mem_meta_t       push_meta, head_meta;

    logic            wb_valid_q, wb_valid_d;
    logic            write_rd_q, write_rd_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    mem_oper_t       mem_oper_q, mem_oper_d;
    logic            load_fault_q, load_fault_d;

    function automatic logic [XLEN-1:0] fmt(
        input logic [XLEN-1:0] raw,
        input logic [2:0]      off,
        input mem_oper_t       op
    );
        logic [XLEN-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (op)
            MEM_LB:  return XLEN'($signed(sh[7:0]));
            MEM_LH:  return XLEN'($signed(sh[15:0]));
            MEM_LW:  return XLEN'($signed(sh[31:0]));
            MEM_LBU: return XLEN'(sh[7:0]);
            MEM_LHU: return XLEN'(sh[15:0]);
            MEM_LWU: return XLEN'(sh[31:0]);
            MEM_LD:  return sh;
            default: return '0;
        endcase
    endfunction

    assign is_mem  = (mem_oper_i != MEM_NOP);
    // Non-mem ops wait for a fully drained queue so WB order stays program order.
    assign stall_o = valid_i & ~flush_i &
                     (is_mem ? (q_full & ~lsu_rvalid_i) : (q_count != '0));
    assign accept  = valid_i & ~stall_o & ~flush_i;
    assign push    = accept & is_mem;

    assign csr_we_o    = csr_we_i & accept & (trap_i == NO_TRAP);
    assign csr_waddr_o = csr_waddr_i;
    assign csr_wdata_o = csr_wdata_i;

    always_comb begin
        push_meta          = '0;
        push_meta.oper     = mem_oper_i;
        push_meta.offset   = 3'(alu_result_i[OW-1:0]);
        push_meta.write_rd = write_rd_i;
        push_meta.rd       = rd_addr_i;
        push_meta.kill     = 1'b0;
    end

    lsu_resp_queue #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (mem_meta_t)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_meta),
        .pop_i       (lsu_rvalid_i),
        .flush_i     (flush_i),
        .head_o      (head_meta),
        .head_kill_o (head_kill),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (q_count)
    );

    // A flush in the pop cycle also kills the popping entry.
    assign head_dead = head_meta.kill | head_kill | flush_i;

    always_comb begin
        wb_valid_d   = wb_valid_q;
        write_rd_d   = write_rd_q;
        rd_addr_d    = rd_addr_q;
        wb_data_d    = wb_data_q;
        mem_oper_d   = mem_oper_q;
        load_fault_d = load_fault_q;
        if (lsu_rvalid_i) begin
            wb_valid_d   = ~head_dead;
            write_rd_d   = head_meta.write_rd & ~lsu_err_i & ~head_dead;
            rd_addr_d    = head_meta.rd;
            wb_data_d    = fmt(lsu_rdata_i, head_meta.offset, head_meta.oper);
            mem_oper_d   = head_meta.oper;
            load_fault_d = lsu_err_i & ~head_dead;
        end else if (accept & ~is_mem) begin
            wb_valid_d   = 1'b1;
            write_rd_d   = write_rd_i;
            rd_addr_d    = rd_addr_i;
            wb_data_d    = alu_result_i;
            mem_oper_d   = mem_oper_i;
            load_fault_d = 1'b0;
        end else begin
            wb_valid_d   = 1'b0;
            write_rd_d   = 1'b0;
            load_fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_q   <= 1'b0;
            write_rd_q   <= 1'b0;
            rd_addr_q    <= '0;
            wb_data_q    <= '0;
            mem_oper_q   <= MEM_NOP;
            load_fault_q <= 1'b0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            write_rd_q   <= write_rd_d;
            rd_addr_q    <= rd_addr_d;
            wb_data_q    <= wb_data_d;
            mem_oper_q   <= mem_oper_d;
            load_fault_q <= load_fault_d;
        end
    end

    assign wb_valid_o   = wb_valid_q;
    assign write_rd_o   = write_rd_q;
    assign rd_addr_o    = rd_addr_q;
    assign wb_data_o    = wb_data_q;
    assign mem_oper_o   = mem_oper_q;
    assign load_fault_o = load_fault_q;

    a_no_orphan_resp: assert property (
        @(posedge clk_i) disable iff (rst_i) !(lsu_rvalid_i && q_empty)
    ) else $error("LSU response with no outstanding request");

endmodule

// File: tb/tb_stage_mem2_mo.sv
// Randomised and directed bench for stage_mem2_mo: an XLEN=32 and an XLEN=64
// instance share one stimulus stream and are checked against a queue model.
module tb_stage_mem2_mo;
    import riscv_pkg::*;

    localparam int MAXO = 2;

    logic        clk, rst, valid, write_rd, csr_we, flush, rvalid, err;
    logic [63:0] alu, csr_wdata, rdata;
    logic [11:0] csr_waddr;
    logic [4:0]  rd;
    mem_oper_t   oper, oper32;
    exc_t        trap;

    logic        a_csr_we, a_wb_valid, a_write_rd, a_fault, a_stall;
    logic [11:0] a_csr_waddr;
    logic [31:0] a_csr_wdata, a_wb_data;
    logic [4:0]  a_rd;
    mem_oper_t   a_mem_oper;

    logic        b_csr_we, b_wb_valid, b_write_rd, b_fault, b_stall;
    logic [11:0] b_csr_waddr;
    logic [63:0] b_csr_wdata, b_wb_data;
    logic [4:0]  b_rd;
    mem_oper_t   b_mem_oper;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        mem_oper_t   op;
        logic [63:0] addr;
        logic        wr;
        logic [4:0]  rd;
        logic        kill;
    } ent_t;

    ent_t        pend[$];
    bit          started = 0;
    bit          e_valid, e_wr, e_fault, e_full;
    logic [4:0]  e_rd;
    mem_oper_t   e_op;
    logic [63:0] e_d32, e_d64;

    // The 32-bit instance sees doubleword/unsigned-word ops as their word forms.
    function automatic mem_oper_t m32(mem_oper_t op);
        case (op)
            MEM_LWU, MEM_LD: return MEM_LW;
            MEM_SD:          return MEM_SW;
            default:         return op;
        endcase
    endfunction

    assign oper32 = m32(oper);

    stage_mem2_mo #(.XLEN(32), .MAX_OUTSTANDING(MAXO)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .alu_result_i(alu[31:0]),
        .mem_oper_i(oper32), .write_rd_i(write_rd), .rd_addr_i(rd),
        .csr_wdata_i(csr_wdata[31:0]), .csr_waddr_i(csr_waddr), .csr_we_i(csr_we),
        .trap_i(trap), .flush_i(flush), .lsu_rvalid_i(rvalid),
        .lsu_rdata_i(rdata[31:0]), .lsu_err_i(err),
        .csr_we_o(a_csr_we), .csr_waddr_o(a_csr_waddr), .csr_wdata_o(a_csr_wdata),
        .wb_valid_o(a_wb_valid), .write_rd_o(a_write_rd), .rd_addr_o(a_rd),
        .wb_data_o(a_wb_data), .mem_oper_o(a_mem_oper), .load_fault_o(a_fault),
        .stall_o(a_stall)
    );

    stage_mem2_mo #(.XLEN(64), .MAX_OUTSTANDING(MAXO)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .alu_result_i(alu),
        .mem_oper_i(oper), .write_rd_i(write_rd), .rd_addr_i(rd),
        .csr_wdata_i(csr_wdata), .csr_waddr_i(csr_waddr), .csr_we_i(csr_we),
        .trap_i(trap), .flush_i(flush), .lsu_rvalid_i(rvalid),
        .lsu_rdata_i(rdata), .lsu_err_i(err),
        .csr_we_o(b_csr_we), .csr_waddr_o(b_csr_waddr), .csr_wdata_o(b_csr_wdata),
        .wb_valid_o(b_wb_valid), .write_rd_o(b_write_rd), .rd_addr_o(b_rd),
        .wb_data_o(b_wb_data), .mem_oper_o(b_mem_oper), .load_fault_o(b_fault),
        .stall_o(b_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    // Load result from the architectural rules: pick the addressed lane, extend.
    function automatic logic [63:0] mfmt(int xl, mem_oper_t op,
                                         logic [63:0] raw, logic [63:0] addr);
        int          off, n;
        bit          sx;
        logic [63:0] w, m, v;
        off = (xl == 32) ? int'(addr[1:0]) : int'(addr[2:0]);
        w   = (xl == 32) ? {32'd0, raw[31:0]} : raw;
        w   = w >> (8 * off);
        n   = 0;
        sx  = 0;
        case (op)
            MEM_LB:  begin n = 8;  sx = 1; end
            MEM_LBU: n = 8;
            MEM_LH:  begin n = 16; sx = 1; end
            MEM_LHU: n = 16;
            MEM_LW:  begin n = 32; sx = 1; end
            MEM_LWU: n = 32;
            MEM_LD:  n = 64;
            default: n = 0;
        endcase
        if (n == 0) return 64'd0;
        m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        v = w & m;
        if (sx && w[n-1]) v = v | ~m;
        if (xl == 32) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    function automatic logic [63:0] align(mem_oper_t op, logic [63:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH:  return a & ~64'h1;
            MEM_LW, MEM_LWU, MEM_SW:  return a & ~64'h3;
            MEM_LD, MEM_SD:           return a & ~64'h7;
            default:                  return a;
        endcase
    endfunction

    // One clock: compare at negedge, advance the model, step to posedge+1.
    task automatic cyc();
        bit   ism, acc, dead, st;
        int   cnt;
        ent_t e;
        @(negedge clk);
        ism = (oper != MEM_NOP);
        cnt = pend.size();
        st  = valid && !flush && (ism ? (cnt == MAXO && !rvalid) : (cnt != 0));
        acc = valid && !st && !flush;
        if (started) begin
            chk("stall32", a_stall, st);
            chk("stall64", b_stall, st);
            chk("csr_we32", a_csr_we, csr_we && acc && trap == NO_TRAP);
            chk("csr_we64", b_csr_we, csr_we && acc && trap == NO_TRAP);
            chk("csr_waddr", a_csr_waddr, csr_waddr);
            chk("csr_wdata32", a_csr_wdata, csr_wdata[31:0]);
            chk("csr_wdata64", b_csr_wdata, csr_wdata);
            chk("wb_valid32", a_wb_valid, e_valid);
            chk("wb_valid64", b_wb_valid, e_valid);
            chk("write_rd32", a_write_rd, e_wr);
            chk("write_rd64", b_write_rd, e_wr);
            chk("fault32", a_fault, e_fault);
            chk("fault64", b_fault, e_fault);
            if (e_full) begin
                chk("rd32", a_rd, e_rd);
                chk("rd64", b_rd, e_rd);
                chk("data32", a_wb_data, e_d32);
                chk("data64", b_wb_data, e_d64);
                chk("oper32", a_mem_oper, m32(e_op));
                chk("oper64", b_mem_oper, e_op);
            end
        end
        if (rst) begin
            pend.delete();
            e_valid = 0; e_wr = 0; e_fault = 0; e_full = 1;
            e_rd = 0; e_op = MEM_NOP; e_d32 = 0; e_d64 = 0;
            started = 1;
        end else begin
            if (rvalid) begin
                if (pend.size() == 0) begin
                    chk("orphan_resp_in_bench", 1, 0);
                    e = '{MEM_NOP, 64'd0, 1'b0, 5'd0, 1'b1};
                end else begin
                    e = pend.pop_front();
                end
                dead    = e.kill || flush;
                e_valid = !dead;
                e_wr    = e.wr && !err && !dead;
                e_fault = err && !dead;
                e_full  = !dead;
                e_rd    = e.rd;
                e_op    = e.op;
                e_d32   = mfmt(32, m32(e.op), rdata, e.addr);
                e_d64   = mfmt(64, e.op, rdata, e.addr);
            end else if (acc && !ism) begin
                e_valid = 1; e_wr = write_rd; e_fault = 0; e_full = 1;
                e_rd = rd; e_op = MEM_NOP;
                e_d32 = {32'd0, alu[31:0]}; e_d64 = alu;
            end else begin
                e_valid = 0; e_wr = 0; e_fault = 0; e_full = 0;
            end
            if (flush) foreach (pend[i]) pend[i].kill = 1;
            if (acc && ism) pend.push_back('{oper, alu, write_rd, rd, 1'b0});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(bit v, mem_oper_t op, logic [63:0] a, bit w, logic [4:0] r);
        valid = v; oper = op; alu = a; write_rd = w; rd = r;
    endtask

    task automatic resp(bit v, logic [63:0] d, bit e);
        rvalid = v; rdata = d; err = e;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; flush = 0; csr_we = 0; csr_waddr = 0; csr_wdata = 0;
        trap = NO_TRAP;
        set_in(0, MEM_NOP, 0, 0, 0);
        resp(0, 0, 0);
        cyc(); cyc();
        rst = 0;
        chk("rst_valid", a_wb_valid, 0);
        chk("rst_data", b_wb_data, 0);
        chk("rst_oper", b_mem_oper, MEM_NOP);

        // LB at byte 3, sign-extended
        set_in(1, MEM_LB, 64'h1003, 1, 1); cyc();
        set_in(0, MEM_NOP, 0, 0, 0); resp(1, 64'h80FF_FF00, 0); cyc();
        resp(0, 0, 0);
        chk("lb_data32", a_wb_data, 32'hFFFF_FF80);
        chk("lb_data64", b_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_wr", a_write_rd, 1);
        chk("lb_valid", a_wb_valid, 1);
        cyc();
        chk("lb_once", a_wb_valid, 0);

        // LWU from the upper word
        set_in(1, MEM_LWU, 64'h2004, 1, 2); cyc();
        set_in(0, MEM_NOP, 0, 0, 0); resp(1, 64'hDEAD_BEEF_0000_0001, 0); cyc();
        resp(0, 0, 0);
        chk("lwu_data64", b_wb_data, 64'h0000_0000_DEAD_BEEF);

        // Queue full: third load stalls unless a response frees a slot
        set_in(1, MEM_LW, 64'h100, 1, 1); cyc();
        set_in(1, MEM_LW, 64'h104, 1, 2); cyc();
        set_in(1, MEM_LW, 64'h108, 1, 3);
        #1 chk("stall_full", a_stall, 1);
        resp(1, 64'h11, 0);
        #1 chk("nostall_resp", a_stall, 0);
        cyc();
        chk("ret1_rd", a_rd, 1);
        chk("ret1_data", a_wb_data, 32'h11);
        set_in(0, MEM_NOP, 0, 0, 0); resp(1, 64'h22, 0); cyc();
        chk("ret2_rd", a_rd, 2);
        resp(1, 64'h33, 0); cyc();
        chk("ret3_rd", a_rd, 3);
        resp(0, 0, 0); cyc();

        // ADD behind a load waits for the drain
        set_in(1, MEM_LW, 64'h200, 1, 7); cyc();
        set_in(1, MEM_NOP, 64'h1234, 1, 5);
        #1 chk("add_stall_q", a_stall, 1);
        cyc();
        resp(1, 64'h77, 0);
        #1 chk("add_stall_pop", a_stall, 1);
        cyc();
        resp(0, 0, 0);
        chk("ld_ret_rd", a_rd, 7);
        chk("ld_ret_valid", a_wb_valid, 1);
        #1 chk("add_go", a_stall, 0);
        cyc();
        chk("add_ret_rd", a_rd, 5);
        chk("add_ret_data", a_wb_data, 32'h1234);
        chk("add_ret_valid", a_wb_valid, 1);
        set_in(0, MEM_NOP, 0, 0, 0);

        // Flush kills queued loads; their responses are consumed silently
        set_in(1, MEM_LW, 64'h300, 1, 8); cyc();
        set_in(1, MEM_LW, 64'h304, 1, 9); cyc();
        set_in(0, MEM_NOP, 0, 0, 0); flush = 1; cyc();
        flush = 0; resp(1, 64'h5, 0); cyc();
        chk("flush_kill1", a_wb_valid, 0);
        cyc();
        chk("flush_kill2", b_wb_valid, 0);
        resp(0, 0, 0);
        set_in(1, MEM_NOP, 64'h5, 1, 3);
        #1 chk("flush_drained", a_stall, 0);
        cyc();
        set_in(0, MEM_NOP, 0, 0, 0);

        // CSR commit gating
        set_in(1, MEM_NOP, 0, 0, 0); csr_we = 1; csr_waddr = 12'h300;
        csr_wdata = 64'hABCD; trap = EXC_ILLEGAL;
        #1 chk("csr_trap", a_csr_we, 0);
        trap = NO_TRAP;
        #1 chk("csr_ok", b_csr_we, 1);
        cyc();
        csr_we = 0;

        // Bus error
        set_in(1, MEM_LW, 64'h400, 1, 4); cyc();
        set_in(0, MEM_NOP, 0, 0, 0); resp(1, 64'hAB, 1); cyc();
        resp(0, 0, 0);
        chk("err_fault", a_fault, 1);
        chk("err_wr", a_write_rd, 0);

        // Reset with two loads in flight
        set_in(1, MEM_LW, 64'h500, 1, 10); cyc();
        set_in(1, MEM_LW, 64'h504, 1, 11); cyc();
        set_in(0, MEM_NOP, 0, 0, 0); rst = 1; cyc();
        rst = 0;
        chk("mrst_valid", a_wb_valid, 0);
        chk("mrst_rd", a_rd, 0);
        chk("mrst_fault", b_fault, 0);
        chk("mrst_oper", b_mem_oper, MEM_NOP);
        cyc();

        for (int c = 0; c < 2000; c++) begin
            mem_oper_t op;
            op        = ($urandom_range(0, 9) < 6) ?
                        mem_oper_t'($urandom_range(1, 11)) : MEM_NOP;
            rst       = ($urandom_range(0, 199) == 0);
            valid     = ($urandom_range(0, 9) < 7);
            oper      = op;
            alu       = align(op, {$urandom, $urandom});
            write_rd  = ($urandom_range(0, 1) == 1);
            rd        = 5'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            csr_we    = ($urandom_range(0, 1) == 1);
            csr_waddr = 12'($urandom);
            csr_wdata = {$urandom, $urandom};
            trap      = ($urandom_range(0, 3) == 0) ? EXC_ECALL : NO_TRAP;
            rvalid    = !rst && pend.size() > 0 && ($urandom_range(0, 1) == 1);
            rdata     = {$urandom, $urandom};
            err       = ($urandom_range(0, 9) == 0);
            cyc();
        end

        rst = 0; flush = 0; csr_we = 0;
        set_in(0, MEM_NOP, 0, 0, 0);
        for (int i = 0; i < 8 && pend.size() > 0; i++) begin
            resp(1, {$urandom, $urandom}, 0);
            cyc();
        end
        resp(0, 0, 0);
        chk("final_drain", pend.size(), 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
